ddr4_cmd_responder: RTL and testbench
=====================================

DDR4_CMD_RESPONDER -- requirements
Module: ddr4_cmd_responder

Interface
REQ-001 SHALL have parameters: T_RCD, default 16, ACT to first RD/WR (cycles); T_RP, default 16, PRE to ACT; T_CL, default 16, RD to first read beat; T_CWL, default 12, WR to first write beat; T_BURST, default 4, beats per burst and minimum column-command spacing; T_RFC, default 260, REF to next command.
REQ-002 SHALL constrain parameters: T_RCD, T_RP and T_RFC in 1..511; T_CL and T_CWL in 1..31; T_BURST in 1..8.
REQ-003 SHALL have ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present this cycle
cmd  in  3  0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR, 5 REF, 6-7 illegal
bg  in  2  bank group
ba  in  2  bank
row  in  14  row address (ACT only)
col  in  10  column address (RD/WR only)
rd_valid  out  1  read beat on bus
wr_valid  out  1  write beat window open
beat  out  3  beat index within current burst
tag  out  14  {bg,ba,col} of burst in progress
open_mask  out  16  bank {bg,ba} is ACTIVE
open_row  out  14  row held by bank addressed by current bg/ba (0 if not ACTIVE)
err  out  1  one-cycle violation pulse
err_code  out  3  violation code, valid when err=1

Function
REQ-004 SHALL keep per-bank state IDLE, ACTIVATING, ACTIVE or PRECHARGING, with a 9-bit down-timer and a 14-bit row register per bank, indexed by {bg,ba}.
REQ-005 SHALL keep a global refresh state (NORMAL/REFRESHING) with a 9-bit timer.
REQ-006 SHALL sample a command only when cmd_valid=1 and cmd is not NOP. Legality SHALL be judged against the registered state at that edge.
REQ-007 ACT on an IDLE bank at cycle n SHALL store row and enter ACTIVATING. The bank SHALL accept RD/WR from cycle n+T_RCD (ACTIVE).
REQ-008 PRE on an ACTIVE bank at cycle n SHALL enter PRECHARGING. The bank SHALL be IDLE and accept ACT from cycle n+T_RP.
REQ-009 PRE on an IDLE or PRECHARGING bank SHALL be a legal no-op and SHALL NOT restart the timer.
REQ-010 REF with all banks IDLE at cycle n SHALL enter REFRESHING. Commands SHALL be accepted again from cycle n+T_RFC.
REQ-011 A RD accepted at cycle n SHALL assert rd_valid on cycles n+T_CL .. n+T_CL+T_BURST-1, with beat counting 0..T_BURST-1 and tag={bg,ba,col}. A WR SHALL do the same on wr_valid with T_CWL.
REQ-012 Column commands (RD/WR) SHALL be spaced at least T_BURST cycles apart.
REQ-013 SHALL reserve data-bus cycles in a shift register of length 31+T_BURST. A RD/WR whose window overlaps a reserved cycle SHALL be rejected.
REQ-014 SHALL detect violations, report the highest-priority one only, and make no state change for the rejected command. Codes, highest priority first:
- 1: any command during REFRESHING.
- 7: illegal cmd.
- 2: ACT to a non-IDLE bank.
- 3: RD/WR to a non-ACTIVE bank, or PRE to an ACTIVATING bank.
- 6: REF with any bank non-IDLE.
- 4: column spacing < T_BURST.
- 5: bus window conflict.
REQ-015 err/err_code SHALL be registered and assert the cycle after the offending edge for exactly one cycle.
REQ-016 Timer expiry coinciding with a command to that bank SHALL be treated as expired, so the command is legal.
REQ-017 open_mask and open_row SHALL reflect registered state.

Reset
REQ-018 When rst_n=0, all banks SHALL go IDLE, timers and rows to 0, refresh to NORMAL, and the pipeline and reservation register SHALL be cleared.
REQ-019 When rst_n=0, all outputs SHALL be 0.
REQ-020 Reset asserted mid-burst SHALL drop rd_valid/wr_valid immediately. No burst SHALL resume after release.
REQ-021 The first command SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-022 ACT bg=1 ba=2 row=0x1A5 at cycle 0, RD col=8 at 16 -> open_mask bit 6 set from cycle 16; rd_valid cycles 32-35; beat 0..3; tag=0x1808; no err.
REQ-023 ACT at 0, RD same bank at 15 -> err=1 code 3 at cycle 16; no rd_valid ever; RD at 16 is accepted.
REQ-024 RD at 0 and WR at 4 on an ACTIVE bank -> code 5 at cycle 5. WR at 8 instead -> wr_valid cycles 20-23, no err.
REQ-025 Bank ACTIVE, REF at 0 -> code 6. PRE at 0, REF at 16, ACT at 275 -> code 1. ACT at 276 -> accepted.
REQ-026 RD at 0, RD at 3 -> code 4. cmd=7 at any time -> code 7, no state change.
REQ-027 rst_n low at cycle 33 of REQ-022 burst -> rd_valid=0 and open_mask=0 immediately; after release, bank IDLE and ACT accepted.

Source files
------------

// File: rtl/ddr4_cmd_responder.sv
// DDR4 command-stream responder: tracks per-bank and refresh timing, flags protocol
// violations, and replays read/write data-beat windows for accepted column commands.
module ddr4_cmd_responder #(
  parameter int unsigned T_RCD   = 16,
  parameter int unsigned T_RP    = 16,
  parameter int unsigned T_CL    = 16,
  parameter int unsigned T_CWL   = 12,
  parameter int unsigned T_BURST = 4,
  parameter int unsigned T_RFC   = 260
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [1:0]  bg,
  input  logic [1:0]  ba,
  input  logic [13:0] row,
  input  logic [9:0]  col,
  output logic        rd_valid,
  output logic        wr_valid,
  output logic [2:0]  beat,
  output logic [13:0] tag,
  output logic [15:0] open_mask,
  output logic [13:0] open_row,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int unsigned NUM_BANKS = 16;
  localparam int unsigned PIPE_LEN  = 31 + T_BURST;
  localparam logic [8:0]  RCD_LD    = 9'(T_RCD - 1);
  localparam logic [8:0]  RP_LD     = 9'(T_RP - 1);
  localparam logic [8:0]  RFC_LD    = 9'(T_RFC - 1);
  localparam logic [2:0]  GAP_LD    = 3'(T_BURST - 1);

  if (T_RCD == 0 || T_RCD > 511 || T_RP == 0 || T_RP > 511 || T_RFC == 0 || T_RFC > 511 ||
      T_CL == 0 || T_CL > 31 || T_CWL == 0 || T_CWL > 31 || T_BURST == 0 || T_BURST > 8)
  begin : g_param_check
    $error("ddr4_cmd_responder: timing parameter out of range");
  end

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_REF  = 3'd5,
    CMD_ILL6 = 3'd6,
    CMD_ILL7 = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_REFRESH  = 3'd1,
    ERR_ACT_BUSY = 3'd2,
    ERR_NOT_OPEN = 3'd3,
    ERR_SPACING  = 3'd4,
    ERR_BUS      = 3'd5,
    ERR_REF_OPEN = 3'd6,
    ERR_ILLEGAL  = 3'd7
  } err_e;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_st_e;

  typedef enum logic {
    REF_NORMAL,
    REF_REFRESHING
  } ref_st_e;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [2:0]  beat;
    logic [13:0] tag;
  } slot_t;

  bank_st_e    bank_st_q  [NUM_BANKS];
  bank_st_e    bank_st_d  [NUM_BANKS];
  logic [8:0]  bank_tmr_q [NUM_BANKS];
  logic [8:0]  bank_tmr_d [NUM_BANKS];
  logic [13:0] bank_row_q [NUM_BANKS];
  logic [13:0] bank_row_d [NUM_BANKS];
  ref_st_e     ref_st_q, ref_st_d;
  logic [8:0]  ref_tmr_q, ref_tmr_d;
  logic [2:0]  col_gap_q, col_gap_d;
  slot_t       pipe_q [PIPE_LEN];
  slot_t       pipe_d [PIPE_LEN];
  logic        err_q, err_d;
  err_e        err_code_q, err_code_d;

  cmd_e        cmd_op;
  logic [3:0]  bank_sel;
  logic        cmd_seen;
  logic        is_col;
  logic        any_open;
  logic        bus_conflict;
  int unsigned col_lat;
  err_e        viol_code;

  assign cmd_op   = cmd_e'(cmd);
  assign bank_sel = {bg, ba};
  assign cmd_seen = cmd_valid && (cmd_op != CMD_NOP);
  assign is_col   = (cmd_op == CMD_RD) || (cmd_op == CMD_WR);

  // Legality is judged purely on registered state; timers that reach zero on this
  // edge have already moved their bank/refresh state, so expiry counts as expired.
  always_comb begin
    any_open = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_st_q[b] != BANK_IDLE) any_open = 1'b1;
    end
    col_lat = (cmd_op == CMD_RD) ? T_CL : T_CWL;
    bus_conflict = 1'b0;
    for (int unsigned i = 0; i < PIPE_LEN; i++) begin
      if (i >= col_lat && i < col_lat + T_BURST && pipe_q[i].valid) bus_conflict = 1'b1;
    end
    viol_code = ERR_NONE;
    if (ref_st_q == REF_REFRESHING) begin
      viol_code = ERR_REFRESH;
    end else if (cmd_op == CMD_ILL6 || cmd_op == CMD_ILL7) begin
      viol_code = ERR_ILLEGAL;
    end else if (cmd_op == CMD_ACT && bank_st_q[bank_sel] != BANK_IDLE) begin
      viol_code = ERR_ACT_BUSY;
    end else if ((is_col && bank_st_q[bank_sel] != BANK_ACTIVE) ||
                 (cmd_op == CMD_PRE && bank_st_q[bank_sel] == BANK_ACTIVATING)) begin
      viol_code = ERR_NOT_OPEN;
    end else if (cmd_op == CMD_REF && any_open) begin
      viol_code = ERR_REF_OPEN;
    end else if (is_col && col_gap_q != 3'd0) begin
      viol_code = ERR_SPACING;
    end else if (is_col && bus_conflict) begin
      viol_code = ERR_BUS;
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_st_d[b]  = bank_st_q[b];
      bank_tmr_d[b] = bank_tmr_q[b];
      bank_row_d[b] = bank_row_q[b];
      case (bank_st_q[b])
        BANK_ACTIVATING: begin
          bank_tmr_d[b] = bank_tmr_q[b] - 9'd1;
          if (bank_tmr_q[b] <= 9'd1) begin
            bank_st_d[b]  = BANK_ACTIVE;
            bank_tmr_d[b] = '0;
          end
        end
        BANK_PRECHARGING: begin
          bank_tmr_d[b] = bank_tmr_q[b] - 9'd1;
          if (bank_tmr_q[b] <= 9'd1) begin
            bank_st_d[b]  = BANK_IDLE;
            bank_tmr_d[b] = '0;
          end
        end
        default: ;
      endcase
    end

    ref_st_d  = ref_st_q;
    ref_tmr_d = ref_tmr_q;
    if (ref_st_q == REF_REFRESHING) begin
      ref_tmr_d = ref_tmr_q - 9'd1;
      if (ref_tmr_q <= 9'd1) begin
        ref_st_d  = REF_NORMAL;
        ref_tmr_d = '0;
      end
    end

    col_gap_d = (col_gap_q != 3'd0) ? col_gap_q - 3'd1 : 3'd0;

    for (int unsigned i = 0; i < PIPE_LEN - 1; i++) begin
      pipe_d[i] = pipe_q[i + 1];
    end
    pipe_d[PIPE_LEN - 1] = '0;

    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    if (cmd_seen) begin
      if (viol_code != ERR_NONE) begin
        err_d      = 1'b1;
        err_code_d = viol_code;
      end else begin
        case (cmd_op)
          CMD_ACT: begin
            bank_row_d[bank_sel] = row;
            if (T_RCD == 1) begin
              bank_st_d[bank_sel]  = BANK_ACTIVE;
              bank_tmr_d[bank_sel] = '0;
            end else begin
              bank_st_d[bank_sel]  = BANK_ACTIVATING;
              bank_tmr_d[bank_sel] = RCD_LD;
            end
          end
          CMD_PRE: begin
            if (bank_st_q[bank_sel] == BANK_ACTIVE) begin
              if (T_RP == 1) begin
                bank_st_d[bank_sel]  = BANK_IDLE;
                bank_tmr_d[bank_sel] = '0;
              end else begin
                bank_st_d[bank_sel]  = BANK_PRECHARGING;
                bank_tmr_d[bank_sel] = RP_LD;
              end
            end
          end
          CMD_RD, CMD_WR: begin
            col_gap_d = GAP_LD;
            // Slot i of the next state is shown on the cycle i+1 edges from now.
            for (int unsigned i = 0; i < PIPE_LEN; i++) begin
              if (i + 1 >= col_lat && i + 1 < col_lat + T_BURST) begin
                pipe_d[i].valid = 1'b1;
                pipe_d[i].wr    = (cmd_op == CMD_WR);
                pipe_d[i].beat  = 3'(i + 1 - col_lat);
                pipe_d[i].tag   = {bg, ba, col};
              end
            end
          end
          CMD_REF: begin
            if (T_RFC > 1) begin
              ref_st_d  = REF_REFRESHING;
              ref_tmr_d = RFC_LD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        bank_st_q[b]  <= BANK_IDLE;
        bank_tmr_q[b] <= '0;
        bank_row_q[b] <= '0;
      end
      ref_st_q   <= REF_NORMAL;
      ref_tmr_q  <= '0;
      col_gap_q  <= '0;
      for (int unsigned i = 0; i < PIPE_LEN; i++) begin
        pipe_q[i] <= '0;
      end
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        bank_st_q[b]  <= bank_st_d[b];
        bank_tmr_q[b] <= bank_tmr_d[b];
        bank_row_q[b] <= bank_row_d[b];
      end
      ref_st_q   <= ref_st_d;
      ref_tmr_q  <= ref_tmr_d;
      col_gap_q  <= col_gap_d;
      for (int unsigned i = 0; i < PIPE_LEN; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign rd_valid = pipe_q[0].valid & ~pipe_q[0].wr;
  assign wr_valid = pipe_q[0].valid & pipe_q[0].wr;
  assign beat     = pipe_q[0].beat;
  assign tag      = pipe_q[0].tag;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign open_row = (bank_st_q[bank_sel] == BANK_ACTIVE) ? bank_row_q[bank_sel] : '0;

  always_comb begin
    open_mask = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      open_mask[b] = (bank_st_q[b] == BANK_ACTIVE);
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_responder.sv
// Scoreboard bench for ddr4_cmd_responder: each issued command queues its expected
// data beats or error pulse; a negedge monitor pops and compares what the DUT shows.
module tb_ddr4_cmd_responder;

  localparam int unsigned T_CL    = 16;
  localparam int unsigned T_CWL   = 12;
  localparam int unsigned T_BURST = 4;

  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_PRE = 3'd2;
  localparam logic [2:0] C_RD  = 3'd3;
  localparam logic [2:0] C_WR  = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = '0;
  logic [1:0]  bg = '0;
  logic [1:0]  ba = '0;
  logic [13:0] row = '0;
  logic [9:0]  col = '0;
  logic        rd_valid;
  logic        wr_valid;
  logic [2:0]  beat;
  logic [13:0] tag;
  logic [15:0] open_mask;
  logic [13:0] open_row;
  logic        err;
  logic [2:0]  err_code;

  ddr4_cmd_responder #(
    .T_RCD  (16),
    .T_RP   (16),
    .T_CL   (T_CL),
    .T_CWL  (T_CWL),
    .T_BURST(T_BURST),
    .T_RFC  (260)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .bg       (bg),
    .ba       (ba),
    .row      (row),
    .col      (col),
    .rd_valid (rd_valid),
    .wr_valid (wr_valid),
    .beat     (beat),
    .tag      (tag),
    .open_mask(open_mask),
    .open_row (open_row),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int unsigned edge_idx = 0;
  always @(posedge clk) edge_idx <= edge_idx + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    int unsigned at;
    logic        wr;
    logic [2:0]  bt;
    logic [13:0] tg;
  } beat_exp_t;

  typedef struct {
    int unsigned at;
    logic [2:0]  code;
  } err_exp_t;

  beat_exp_t exp_beats[$];
  err_exp_t  exp_errs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    beat_exp_t be;
    err_exp_t  ee;
    if (rst_n) begin
      while (exp_beats.size() > 0 && exp_beats[0].at < edge_idx) begin
        check("missed_beat", 32'(edge_idx), 32'(exp_beats[0].at));
        void'(exp_beats.pop_front());
      end
      while (exp_errs.size() > 0 && exp_errs[0].at < edge_idx) begin
        check("missed_err", 32'(edge_idx), 32'(exp_errs[0].at));
        void'(exp_errs.pop_front());
      end
      if (rd_valid || wr_valid) begin
        if (exp_beats.size() == 0 || exp_beats[0].at != edge_idx) begin
          check("unexp_beat", 32'({rd_valid, wr_valid}), 32'd0);
        end else begin
          be = exp_beats.pop_front();
          check("beat_wr", 32'(wr_valid), 32'(be.wr));
          check("beat_rd", 32'(rd_valid), 32'(!be.wr));
          check("beat_idx", 32'(beat), 32'(be.bt));
          check("beat_tag", 32'(tag), 32'(be.tg));
        end
      end
      if (err) begin
        if (exp_errs.size() == 0 || exp_errs[0].at != edge_idx) begin
          check("unexp_err", 32'({err, err_code}), 32'd0);
        end else begin
          ee = exp_errs.pop_front();
          check("err_code", 32'(err_code), 32'(ee.code));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [1:0] g, input logic [1:0] a,
                       input logic [13:0] r, input logic [9:0] co, input logic [2:0] ec);
    int unsigned n;
    int unsigned lat;
    cmd_valid = 1'b1;
    cmd = c;
    bg  = g;
    ba  = a;
    row = r;
    col = co;
    @(posedge clk);
    #1;
    n = edge_idx;
    cmd_valid = 1'b0;
    cmd = '0;
    lat = (c == C_WR) ? T_CWL : T_CL;
    if (ec != 3'd0) begin
      exp_errs.push_back('{at: n, code: ec});
    end else if (c == C_RD || c == C_WR) begin
      for (int unsigned k = 0; k < T_BURST; k++) begin
        exp_beats.push_back('{at: n + lat - 1 + k, wr: (c == C_WR), bt: 3'(k), tg: {g, a, co}});
      end
    end
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("beats_drained", 32'(exp_beats.size()), 32'd0);
    check("errs_drained", 32'(exp_errs.size()), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("rst_outputs", 32'({rd_valid, wr_valid, beat, tag, err, err_code}), 32'd0);
    check("rst_open_mask", 32'(open_mask), 32'd0);
    check("rst_open_row", 32'(open_row), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ACT then RD on bank {1,2}
    issue(C_ACT, 2'd1, 2'd2, 14'h1A5, 10'd0, 3'd0);
    idle(14);
    check("s1_mask_before", 32'(open_mask), 32'd0);
    check("s1_row_before", 32'(open_row), 32'd0);
    idle(1);
    check("s1_mask_open", 32'(open_mask), 32'h0040);
    check("s1_open_row", 32'(open_row), 32'h1A5);
    issue(C_RD, 2'd1, 2'd2, 14'd0, 10'd8, 3'd0);
    idle(40);

    // RD one cycle too early, then on time
    do_reset();
    issue(C_ACT, 2'd0, 2'd0, 14'd5, 10'd0, 3'd0);
    idle(14);
    issue(C_RD, 2'd0, 2'd0, 14'd0, 10'd3, 3'd3);
    issue(C_RD, 2'd0, 2'd0, 14'd0, 10'd3, 3'd0);
    idle(40);

    // Bus window conflict, then a non-overlapping WR
    do_reset();
    issue(C_ACT, 2'd0, 2'd1, 14'h2A, 10'd0, 3'd0);
    idle(15);
    issue(C_RD, 2'd0, 2'd1, 14'd0, 10'h010, 3'd0);
    idle(3);
    issue(C_WR, 2'd0, 2'd1, 14'd0, 10'h011, 3'd5);
    idle(3);
    issue(C_WR, 2'd0, 2'd1, 14'd0, 10'h012, 3'd0);
    idle(30);

    // Spacing, illegal cmds, ACT/PRE/REF/RD legality on the same open bank
    issue(C_RD, 2'd0, 2'd1, 14'd0, 10'h020, 3'd0);
    idle(2);
    issue(C_RD, 2'd0, 2'd1, 14'd0, 10'h021, 3'd4);
    issue(C_RD, 2'd0, 2'd1, 14'd0, 10'h022, 3'd0);
    issue(3'd7, 2'd2, 2'd2, 14'd9, 10'd0, 3'd7);
    issue(3'd6, 2'd0, 2'd1, 14'd9, 10'd0, 3'd7);
    check("s4_mask_kept", 32'(open_mask), 32'h0002);
    issue(C_ACT, 2'd0, 2'd1, 14'h11, 10'd0, 3'd2);
    issue(C_ACT, 2'd3, 2'd3, 14'h77, 10'd0, 3'd0);
    issue(C_PRE, 2'd3, 2'd3, 14'd0, 10'd0, 3'd3);
    issue(C_REF, 2'd0, 2'd0, 14'd0, 10'd0, 3'd6);
    issue(C_RD, 2'd2, 2'd2, 14'd0, 10'd0, 3'd3);
    check("s4_mask_activating", 32'(open_mask), 32'h0002);
    idle(40);
    check("s4_mask_both", 32'(open_mask), 32'h8002);

    // Refresh gating and PRE no-ops
    do_reset();
    issue(C_PRE, 2'd0, 2'd0, 14'd0, 10'd0, 3'd0);
    issue(C_ACT, 2'd2, 2'd0, 14'h3, 10'd0, 3'd0);
    idle(15);
    issue(C_REF, 2'd0, 2'd0, 14'd0, 10'd0, 3'd6);
    issue(C_PRE, 2'd2, 2'd0, 14'd0, 10'd0, 3'd0);
    issue(C_PRE, 2'd2, 2'd0, 14'd0, 10'd0, 3'd0);
    idle(14);
    check("s5_closed", 32'(open_mask), 32'd0);
    issue(C_REF, 2'd0, 2'd0, 14'd0, 10'd0, 3'd0);
    idle(258);
    issue(C_ACT, 2'd2, 2'd0, 14'h3, 10'd0, 3'd1);
    issue(C_ACT, 2'd2, 2'd0, 14'h3, 10'd0, 3'd0);
    idle(15);
    check("s5_reopen", 32'(open_mask), 32'h0100);
    check("s5_row", 32'(open_row), 32'h3);

    // Reset in the middle of a read burst
    do_reset();
    issue(C_ACT, 2'd1, 2'd2, 14'h1A5, 10'd0, 3'd0);
    idle(15);
    issue(C_RD, 2'd1, 2'd2, 14'd0, 10'd8, 3'd0);
    idle(16);
    @(negedge clk);
    #1;
    check("s6_midburst", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("s6_rst_mask", 32'(open_mask), 32'd0);
    check("s6_beats_dropped", 32'(exp_beats.size()), 32'd2);
    exp_beats.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s6_idle_after", 32'(open_mask), 32'd0);
    issue(C_ACT, 2'd1, 2'd2, 14'h1A5, 10'd0, 3'd0);
    idle(15);
    check("s6_reopen", 32'(open_mask), 32'h0040);
    idle(40);

    check("final_beats_left", 32'(exp_beats.size()), 32'd0);
    check("final_errs_left", 32'(exp_errs.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
